// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: shares one memory port between instruction fetch (requester 1)
// and the load/store unit (requester 2). Round-robin on contention. Each access uses
// a valid/ready handshake to memory and ends with a one-cycle ack to the winner.
// Optional feature: define ELBETH_ARB_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES cycles without mem_ready (pulses timeout_err, returns rdata 0).
module elbeth_mem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  // Requester 1 (instruction fetch)
  input  logic                  req_1,
  input  logic [DATA_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  input  logic                  we_1,
  output logic                  ack_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  // Requester 2 (load/store unit)
  input  logic                  req_2,
  input  logic [DATA_WIDTH-1:0] addr_2,
  input  logic [DATA_WIDTH-1:0] wdata_2,
  input  logic                  we_2,
  output logic                  ack_2,
  output logic [DATA_WIDTH-1:0] rdata_2,
  // Memory port
  output logic                  mem_valid,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  // Status
  output logic                  grant_sel,
  output logic                  busy,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServe1 = 2'd1,
    StServe2 = 2'd2
  } state_e;

  state_e                state_q;
  // 1 = requester 1 was granted last; resets to 0 so requester 1 wins the first tie
  logic                  last_1_q;
  logic                  mem_valid_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic                  mem_we_q;
  logic                  ack_1_q;
  logic                  ack_2_q;
  logic [DATA_WIDTH-1:0] rdata_1_q;
  logic [DATA_WIDTH-1:0] rdata_2_q;
  logic                  grant_sel_q;
  logic                  busy_q;

  logic                  pick_1;
  logic                  pick_2;
  logic                  serving_1;

  // Winner selection in IDLE: a tie goes to the requester that was not granted last
  always_comb begin
    pick_1    = req_1 & (~req_2 | ~last_1_q);
    pick_2    = req_2 & (~req_1 | last_1_q);
    serving_1 = (state_q == StServe1);
  end

`ifdef ELBETH_ARB_TIMEOUT_EN
  localparam int unsigned   CntW    = $clog2(TIMEOUT_CYCLES + 1);
  // Abort happens on the edge that would complete the TIMEOUT_CYCLES-th wait cycle
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] wait_cnt_q;
  logic            timeout_err_q;

  // Arbitration FSM with registered outputs and wait-cycle watchdog
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      last_1_q      <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      ack_1_q       <= 1'b0;
      ack_2_q       <= 1'b0;
      rdata_1_q     <= '0;
      rdata_2_q     <= '0;
      grant_sel_q   <= 1'b0;
      busy_q        <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      ack_1_q       <= 1'b0;
      ack_2_q       <= 1'b0;
      timeout_err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_1) begin
            state_q     <= StServe1;
            last_1_q    <= 1'b1;
            grant_sel_q <= 1'b1;
            mem_addr_q  <= addr_1;
            mem_wdata_q <= wdata_1;
            mem_we_q    <= we_1;
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            wait_cnt_q  <= '0;
          end else if (pick_2) begin
            state_q     <= StServe2;
            last_1_q    <= 1'b0;
            grant_sel_q <= 1'b0;
            mem_addr_q  <= addr_2;
            mem_wdata_q <= wdata_2;
            mem_we_q    <= we_2;
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            wait_cnt_q  <= '0;
          end
        end
        StServe1, StServe2: begin
          if (mem_ready) begin
            // Completion beats a coincident timeout
            state_q     <= StIdle;
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            if (serving_1) begin
              ack_1_q   <= 1'b1;
              rdata_1_q <= mem_rdata;
            end else begin
              ack_2_q   <= 1'b1;
              rdata_2_q <= mem_rdata;
            end
          end else if (wait_cnt_q == CntLast) begin
            state_q       <= StIdle;
            mem_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            if (serving_1) begin
              ack_1_q   <= 1'b1;
              rdata_1_q <= '0;
            end else begin
              ack_2_q   <= 1'b1;
              rdata_2_q <= '0;
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign timeout_err = timeout_err_q;
`else
  // Without the watchdog the timeout limit is irrelevant
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;

  // Arbitration FSM with registered outputs; waits for mem_ready indefinitely
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      last_1_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      ack_1_q     <= 1'b0;
      ack_2_q     <= 1'b0;
      rdata_1_q   <= '0;
      rdata_2_q   <= '0;
      grant_sel_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      ack_1_q <= 1'b0;
      ack_2_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_1) begin
            state_q     <= StServe1;
            last_1_q    <= 1'b1;
            grant_sel_q <= 1'b1;
            mem_addr_q  <= addr_1;
            mem_wdata_q <= wdata_1;
            mem_we_q    <= we_1;
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end else if (pick_2) begin
            state_q     <= StServe2;
            last_1_q    <= 1'b0;
            grant_sel_q <= 1'b0;
            mem_addr_q  <= addr_2;
            mem_wdata_q <= wdata_2;
            mem_we_q    <= we_2;
            mem_valid_q <= 1'b1;
            busy_q      <= 1'b1;
          end
        end
        StServe1, StServe2: begin
          if (mem_ready) begin
            state_q     <= StIdle;
            mem_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            if (serving_1) begin
              ack_1_q   <= 1'b1;
              rdata_1_q <= mem_rdata;
            end else begin
              ack_2_q   <= 1'b1;
              rdata_2_q <= mem_rdata;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign timeout_err = 1'b0;
`endif

  // Registered state drives every output directly
  always_comb begin
    mem_valid = mem_valid_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    mem_we    = mem_we_q;
    ack_1     = ack_1_q;
    ack_2     = ack_2_q;
    rdata_1   = rdata_1_q;
    rdata_2   = rdata_2_q;
    grant_sel = grant_sel_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Directed bench for elbeth_mem_arbiter: reset, single read, round-robin contention,
// wait states with stable outputs, reset mid-access and (when ELBETH_ARB_TIMEOUT_EN
// is defined) the timeout abort.
module tb_elbeth_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        req_1, we_1, ack_1;
  logic [31:0] addr_1, wdata_1, rdata_1;
  logic        req_2, we_2, ack_2;
  logic [31:0] addr_2, wdata_2, rdata_2;
  logic        mem_valid, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        grant_sel, busy, timeout_err;

  int n_total;
  int n_bad;

  elbeth_mem_arbiter #(
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_1      (req_1),
    .addr_1     (addr_1),
    .wdata_1    (wdata_1),
    .we_1       (we_1),
    .ack_1      (ack_1),
    .rdata_1    (rdata_1),
    .req_2      (req_2),
    .addr_2     (addr_2),
    .wdata_2    (wdata_2),
    .we_2       (we_2),
    .ack_2      (ack_2),
    .rdata_2    (rdata_2),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .grant_sel  (grant_sel),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    req_1     = 1'b0; addr_1 = '0; wdata_1 = '0; we_1 = 1'b0;
    req_2     = 1'b0; addr_2 = '0; wdata_2 = '0; we_2 = 1'b0;
    mem_ready = 1'b0; mem_rdata = '0;

    // Reset then idle
    step();
    step();
    rst = 1'b0;
    repeat (10) step();
    check("rst_valid", mem_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_we", mem_we, 0);
    check("rst_acks", {ack_1, ack_2}, 0);
    check("rst_rdata1", rdata_1, 0);
    check("rst_rdata2", rdata_2, 0);
    check("rst_grant", grant_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);

    // Single read from requester 1, zero wait states
    req_1 = 1'b1; addr_1 = 32'h0000_0100; we_1 = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    check("rd_valid", mem_valid, 1);
    check("rd_addr", mem_addr, 32'h100);
    check("rd_we", mem_we, 0);
    check("rd_grant", grant_sel, 1);
    check("rd_busy", busy, 1);
    check("rd_noack", ack_1, 0);
    step();
    check("rd_ack", {ack_1, ack_2}, 2'b10);
    check("rd_rdata", rdata_1, 32'h1234_5678);
    check("rd_valid_lo", mem_valid, 0);
    check("rd_busy_lo", busy, 0);
    req_1 = 1'b0;
    step();
    check("rd_ack_pulse", ack_1, 0);
    check("rd_grant_hold", grant_sel, 1);

    // Contention after a fresh reset: grants alternate 1,2,1,2
    rst = 1'b1;
    step();
    rst = 1'b0;
    addr_1 = 32'h10; addr_2 = 32'h20; mem_rdata = 32'h55AA_0000;
    req_1 = 1'b1; req_2 = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp1;
      exp1 = (i % 2 == 0);
      step();
      check($sformatf("rr%0d_grant", i), grant_sel, {31'd0, exp1});
      check($sformatf("rr%0d_addr", i), mem_addr, exp1 ? 32'h10 : 32'h20);
      check($sformatf("rr%0d_valid", i), mem_valid, 1);
      check($sformatf("rr%0d_noack", i), {ack_1, ack_2}, 0);
      step();
      check($sformatf("rr%0d_ack", i), {ack_1, ack_2}, exp1 ? 2'b10 : 2'b01);
      check($sformatf("rr%0d_idle", i), mem_valid, 0);
    end
    req_1 = 1'b0; req_2 = 1'b0;
    check("rr_rdata2", rdata_2, 32'h55AA_0000);

    // Requester 2 write with wait states; input changes must not leak through
    mem_ready = 1'b0;
    req_2 = 1'b1; we_2 = 1'b1; addr_2 = 32'h200; wdata_2 = 32'hCAFE_F00D;
    step();
    check("ws_valid", mem_valid, 1);
    check("ws_addr", mem_addr, 32'h200);
    check("ws_wdata", mem_wdata, 32'hCAFE_F00D);
    check("ws_we", mem_we, 1);
    check("ws_grant", grant_sel, 0);
    addr_2 = 32'h300; wdata_2 = 32'h0; we_2 = 1'b0; req_2 = 1'b0;
    req_1 = 1'b1; addr_1 = 32'h999;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("ws%0d_addr", i), mem_addr, 32'h200);
      check($sformatf("ws%0d_wdata", i), mem_wdata, 32'hCAFE_F00D);
      check($sformatf("ws%0d_hold", i), {mem_valid, busy, ack_1, ack_2, mem_we}, 5'b11001);
    end
    req_1 = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    check("ws_ack", {ack_1, ack_2}, 2'b01);
    check("ws_rdata", rdata_2, 32'hDEAD_BEEF);
    check("ws_valid_lo", mem_valid, 0);
    mem_ready = 1'b0;
    step();
    check("ws_ack_pulse", {ack_1, ack_2}, 0);
    check("ws_grant_hold", grant_sel, 0);

    // Reset in the middle of a requester 1 access
    req_1 = 1'b1; addr_1 = 32'h400; we_1 = 1'b0;
    step();
    check("mr_valid", mem_valid, 1);
    check("mr_grant", grant_sel, 1);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("mr_async_valid", mem_valid, 0);
    check("mr_async_busy", busy, 0);
    check("mr_async_grant", grant_sel, 0);
    check("mr_async_addr", mem_addr, 0);
    step();
    check("mr_noack", ack_1, 0);
    // Tie right after release must go to requester 1 again
    req_2 = 1'b1; addr_2 = 32'h500; we_2 = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    rst = 1'b0;
    step();
    check("mr_tie_grant", grant_sel, 1);
    check("mr_tie_addr", mem_addr, 32'h400);
    step();
    check("mr_tie_ack", {ack_1, ack_2}, 2'b10);
    check("mr_tie_rdata", rdata_1, 32'h1111_2222);
    req_1 = 1'b0; req_2 = 1'b0; mem_ready = 1'b0;
    step();

`ifdef ELBETH_ARB_TIMEOUT_EN
    // Abort after 4 wait cycles without mem_ready
    req_1 = 1'b1; addr_1 = 32'h600;
    step();
    check("to_valid", mem_valid, 1);
    req_1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("to%0d_wait", i), {mem_valid, ack_1, timeout_err}, 3'b100);
    end
    step();
    check("to_abort", {mem_valid, ack_1, timeout_err}, 3'b011);
    check("to_rdata", rdata_1, 0);
    step();
    check("to_pulse", {ack_1, timeout_err}, 0);
    // mem_ready on the timeout edge completes normally
    req_1 = 1'b1;
    step();
    req_1 = 1'b0;
    repeat (3) step();
    check("tr_wait", {mem_valid, ack_1}, 2'b10);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    step();
    check("tr_ack", {ack_1, timeout_err}, 2'b10);
    check("tr_rdata", rdata_1, 32'h77);
    mem_ready = 1'b0;
    step();
`else
    // Without the watchdog a long wait never aborts
    req_1 = 1'b1; addr_1 = 32'h600;
    step();
    req_1 = 1'b0;
    repeat (12) step();
    check("nt_wait", {mem_valid, ack_1, timeout_err}, 3'b100);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    step();
    check("nt_ack", {ack_1, timeout_err}, 2'b10);
    check("nt_rdata", rdata_1, 32'h77);
    mem_ready = 1'b0;
    step();
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
